// File: rtl/trace_tx.sv
// Retirement-trace exporter: buffers {seq,pc,instr} per commit and streams 10-byte frames.
// Latency commit->SYNC byte is 2 cycles; tx_data/byte_idx hold under !tx_ready, full FIFO drops.

module trace_fifo #(
  parameter int W     = 72,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;
  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);

  // Push while full is legal only alongside a pop: the head is read before the slot is overwritten.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

module trace_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          ADDR_W     = 3,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              commit,
  input  logic [31:0]       pc,
  input  logic [31:0]       instr,
  input  logic              clr_ovf,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              overflow,
  output logic [15:0]       drop_cnt,
  output logic [ADDR_W:0]   fifo_level
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [71:0] frame_q, frame_d;
  logic [7:0]  seq_q, seq_d;
  logic        overflow_q, overflow_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        capture, last_hs, push, pop, drop;
  logic        fifo_empty, fifo_full;
  logic [71:0] fifo_head;

  assign capture = commit & en;
  assign last_hs = (state_q == SEND) && tx_ready && (byte_idx_q == 4'd9);
  assign pop     = !fifo_empty && ((state_q == IDLE) || last_hs);
  assign push    = capture && (!fifo_full || pop);
  assign drop    = capture && !push;

  trace_fifo #(.W(72), .DEPTH(FIFO_DEPTH), .AW(ADDR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({seq_q, pc, instr}),
    .dout  (fifo_head),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    frame_d    = frame_q;
    if (pop) begin
      frame_d    = fifo_head;
      byte_idx_d = 4'd0;
      state_d    = SEND;
    end else if ((state_q == SEND) && tx_ready) begin
      if (byte_idx_q == 4'd9) state_d = IDLE;
      else                    byte_idx_d = byte_idx_q + 4'd1;
    end
  end

  // seq advances on every capture, dropped or not, so the host can see gaps.
  always_comb begin
    seq_d      = capture ? seq_q + 8'd1 : seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    if (state_q == SEND) begin
      case (byte_idx_q)
        4'd0:    tx_data = SYNC_BYTE;
        4'd1:    tx_data = frame_q[71:64];
        4'd2:    tx_data = frame_q[63:56];
        4'd3:    tx_data = frame_q[55:48];
        4'd4:    tx_data = frame_q[47:40];
        4'd5:    tx_data = frame_q[39:32];
        4'd6:    tx_data = frame_q[31:24];
        4'd7:    tx_data = frame_q[23:16];
        4'd8:    tx_data = frame_q[15:8];
        4'd9:    tx_data = frame_q[7:0];
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign tx_valid = (state_q == SEND);
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_idx_q <= 4'd0;
      frame_q    <= '0;
      seq_q      <= 8'd0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      frame_q    <= frame_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_trace_tx.sv
// Directed bench for trace_tx: vector table for the basic frame plus hand sequences for corner cases.
module tb_trace_tx;
  logic        clk = 1'b0;
  logic        rst, en, commit, clr_ovf, tx_ready;
  logic [31:0] pc, instr;
  logic [7:0]  tx_data;
  logic        tx_valid, overflow;
  logic [15:0] drop_cnt;
  logic [3:0]  fifo_level;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        c;
    logic [31:0] p;
    logic [31:0] i;
    logic        r;
    logic        ev;
    logic [7:0]  ed;
  } vec_t;

  vec_t       t1[13];
  logic [7:0] exp1[10];
  logic       pat[6];

  trace_tx #(.FIFO_DEPTH(8), .ADDR_W(3), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .commit     (commit),
    .pc         (pc),
    .instr      (instr),
    .clr_ovf    (clr_ovf),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] fbyte(input logic [7:0] s, input logic [31:0] p,
                                       input logic [31:0] ins, input int idx);
    case (idx)
      0: return 8'hA5;
      1: return s;
      2: return p[31:24];
      3: return p[23:16];
      4: return p[15:8];
      5: return p[7:0];
      6: return ins[31:24];
      7: return ins[23:16];
      8: return ins[15:8];
      default: return ins[7:0];
    endcase
  endfunction

  function automatic vec_t mk(input logic c, input logic [31:0] p, input logic [31:0] i,
                              input logic r, input logic ev, input logic [7:0] ed);
    vec_t v;
    v.c = c; v.p = p; v.i = i; v.r = r; v.ev = ev; v.ed = ed;
    return v;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0; commit = 1'b0; en = 1'b1; clr_ovf = 1'b0; tx_ready = 1'b0;
    pc = 32'h0; instr = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    exp1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05};
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    t1[0] = mk(1'b1, 32'h00003000, 32'h20080005, 1'b1, 1'b0, 8'h00);
    t1[1] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h00);
    for (int j = 0; j < 10; j++) t1[2+j] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, exp1[j]);
    t1[12] = mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 8'h00);

    rst = 1'b1; en = 1'b1; commit = 1'b0; clr_ovf = 1'b0; tx_ready = 1'b0;
    pc = 32'h0; instr = 32'h0;

    // Reset state and single frame
    do_reset();
    chk("rst_vld", 32'(tx_valid), 32'd0);
    chk("rst_dat", 32'(tx_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_lvl", 32'(fifo_level), 32'd0);
    for (int k = 0; k < 13; k++) begin
      commit = t1[k].c; pc = t1[k].p; instr = t1[k].i; tx_ready = t1[k].r;
      chk($sformatf("t1_vld[%0d]", k), 32'(tx_valid), 32'(t1[k].ev));
      if (t1[k].ev) chk($sformatf("t1_dat[%0d]", k), 32'(tx_data), 32'(t1[k].ed));
      @(negedge clk);
    end

    // Backpressure
    do_reset();
    commit = 1'b1; pc = 32'h00003000; instr = 32'h20080005; tx_ready = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    @(negedge clk);
    begin
      int idx = 0;
      int c = 0;
      while (idx < 10 && c < 40) begin
        tx_ready = pat[c % 6];
        chk($sformatf("bp_vld[%0d]", c), 32'(tx_valid), 32'd1);
        chk($sformatf("bp_dat[%0d]", c), 32'(tx_data), 32'(exp1[idx]));
        if (tx_ready) idx++;
        c++;
        @(negedge clk);
      end
      chk("bp_bytes", 32'(idx), 32'd10);
      chk("bp_idle", 32'(tx_valid), 32'd0);
    end

    // Overflow and back-to-back drain
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      commit = 1'b1; pc = 32'h3000 + 32'(4 * i); instr = 32'hAB000000 | 32'(i);
      @(negedge clk);
    end
    commit = 1'b0;
    chk("ovf_lvl", 32'(fifo_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd3);
    tx_ready = 1'b1;
    for (int f = 0; f < 9; f++) begin
      for (int b = 0; b < 10; b++) begin
        chk($sformatf("drn_vld[%0d.%0d]", f, b), 32'(tx_valid), 32'd1);
        chk($sformatf("drn_dat[%0d.%0d]", f, b), 32'(tx_data),
            32'(fbyte(8'(f), 32'h3000 + 32'(4 * f), 32'hAB000000 | 32'(f), b)));
        @(negedge clk);
      end
    end
    chk("drn_idle", 32'(tx_valid), 32'd0);
    chk("drn_lvl", 32'(fifo_level), 32'd0);
    commit = 1'b1; pc = 32'h00004000; instr = 32'h12345678;
    @(negedge clk);
    commit = 1'b0;
    @(negedge clk);
    chk("seq0c_vld", 32'(tx_valid), 32'd1);
    chk("seq0c_sync", 32'(tx_data), 32'hA5);
    @(negedge clk);
    chk("seq0c_seq", 32'(tx_data), 32'h0C);
    repeat (9) @(negedge clk);
    chk("clr_pre_ovf", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);

    // Full FIFO with simultaneous pop
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      commit = 1'b1; pc = 32'h5000 + 32'(4 * i); instr = 32'(i);
      @(negedge clk);
    end
    commit = 1'b0;
    chk("fp_lvl_pre", 32'(fifo_level), 32'd8);
    tx_ready = 1'b1;
    repeat (9) @(negedge clk);
    chk("fp_last_vld", 32'(tx_valid), 32'd1);
    commit = 1'b1; pc = 32'h00006000; instr = 32'h00000066;
    @(negedge clk);
    commit = 1'b0; tx_ready = 1'b0;
    chk("fp_lvl", 32'(fifo_level), 32'd8);
    chk("fp_drop", 32'(drop_cnt), 32'd0);
    chk("fp_ovf", 32'(overflow), 32'd0);
    chk("fp_b2b_vld", 32'(tx_valid), 32'd1);
    chk("fp_b2b_sync", 32'(tx_data), 32'hA5);
    @(negedge clk);
    chk("fp_hold", 32'(tx_data), 32'hA5);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("fp_seq1", 32'(tx_data), 32'h01);

    // Asynchronous reset mid-frame
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      commit = 1'b1; pc = 32'h7000 + 32'(4 * i); instr = 32'(i);
      @(negedge clk);
    end
    commit = 1'b0;
    chk("mr_pre_ovf", 32'(overflow), 32'd1);
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mr_pre_vld", 32'(tx_valid), 32'd1);
    #2 rst = 1'b0;
    #1 chk("mr_async_vld", 32'(tx_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk("mr_lvl", 32'(fifo_level), 32'd0);
    chk("mr_ovf", 32'(overflow), 32'd0);
    chk("mr_drop", 32'(drop_cnt), 32'd0);
    chk("mr_vld", 32'(tx_valid), 32'd0);
    commit = 1'b1; pc = 32'h00007700; instr = 32'h00000077;
    @(negedge clk);
    commit = 1'b0;
    @(negedge clk);
    chk("mr_new_vld", 32'(tx_valid), 32'd1);
    chk("mr_new_sync", 32'(tx_data), 32'hA5);
    @(negedge clk);
    chk("mr_new_seq", 32'(tx_data), 32'h00);
    repeat (9) @(negedge clk);

    // Enable gating
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1; pc = 32'h9000 + 32'(i); instr = 32'h99;
      @(negedge clk);
    end
    commit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("en0_vld[%0d]", i), 32'(tx_valid), 32'd0);
      @(negedge clk);
    end
    chk("en0_lvl", 32'(fifo_level), 32'd0);
    en = 1'b1;
    commit = 1'b1; pc = 32'h00008000; instr = 32'h00000088;
    @(negedge clk);
    commit = 1'b0;
    @(negedge clk);
    chk("en1_vld", 32'(tx_valid), 32'd1);
    @(negedge clk);
    chk("en1_seq", 32'(tx_data), 32'h01);
    repeat (9) @(negedge clk);
    chk("en1_idle", 32'(tx_valid), 32'd0);

    // drop_cnt saturation: 9 accepted, then 65534 drops, then 3 more
    tx_ready = 1'b0;
    commit = 1'b1; pc = 32'h0000A000; instr = 32'h000000AA;
    repeat (9 + 65534) @(negedge clk);
    commit = 1'b0;
    chk("sat_fffe", 32'(drop_cnt), 32'h0000FFFE);
    commit = 1'b1;
    repeat (3) @(negedge clk);
    commit = 1'b0;
    chk("sat_ffff", 32'(drop_cnt), 32'h0000FFFF);
    chk("sat_ovf", 32'(overflow), 32'd1);
    chk("sat_lvl", 32'(fifo_level), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
